// File: rtl/mdu_hilo_if.sv
// Decode-to-MDU bundle: issue, HI/LO moves and reads,
// plus the result registers and interlock coming back.
interface mdu_hilo_if;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        mthi;
    logic        mtlo;
    logic        mfhi;
    logic        mflo;
    logic [31:0] wdata;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;
    logic        stall;

    modport master (
        output start, op, a, b, mthi, mtlo, mfhi, mflo, wdata,
        input  hi, lo, busy, done, stall
    );

    modport slave (
        input  start, op, a, b, mthi, mtlo, mfhi, mflo, wdata,
        output hi, lo, busy, done, stall
    );
endinterface

// File: rtl/mdu_hilo.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO.
// Magnitude datapath over ITER steps, then one sign-fix step.
module mdu_hilo #(
    parameter int ITER = 32
) (
    input  logic       clk,
    input  logic       rst,
    mdu_hilo_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic [1:0]  op_q;
    logic [31:0] ma;
    logic [31:0] mb;
    logic [31:0] a_q;
    logic        neg_q;
    logic        rneg_q;
    logic        bz_q;
    logic [63:0] acc;
    logic [4:0]  count;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic        done_q;

    logic        sgn_in;
    logic [31:0] ma_in;
    logic [31:0] mb_in;
    logic [32:0] mul_sum;
    logic [32:0] rsh;
    logic [33:0] dif;
    logic        qbit;
    logic [31:0] rnew;
    logic [63:0] prod_fix;
    logic [31:0] q_fix;
    logic [31:0] r_fix;

    // Operand magnitudes; -0x80000000 wraps to itself as unsigned.
    always_comb begin
        sgn_in = ~bus.op[0];
        ma_in  = (sgn_in && bus.a[31]) ? (32'd0 - bus.a) : bus.a;
        mb_in  = (sgn_in && bus.b[31]) ? (32'd0 - bus.b) : bus.b;
    end

    // One shift-add step and one restoring-divide step, plus sign fix.
    always_comb begin
        mul_sum  = {1'b0, acc[63:32]} + {1'b0, (mb[0] ? ma : 32'd0)};
        rsh      = {acc[63:32], ma[31]};
        dif      = {1'b0, rsh} - {2'b0, mb};
        qbit     = ~dif[33];
        rnew     = qbit ? dif[31:0] : rsh[31:0];
        prod_fix = neg_q ? (64'd0 - acc) : acc;
        q_fix    = neg_q ? (32'd0 - acc[31:0]) : acc[31:0];
        r_fix    = rneg_q ? (32'd0 - acc[63:32]) : acc[63:32];
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next state: idle until issue, ITER calc edges, one fix edge.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (bus.start) state_nxt = CALC;
            CALC: if (count == 5'(ITER - 1)) state_nxt = FIX;
            FIX:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath, iteration counter and the HI/LO result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q   <= 2'd0;
            ma     <= 32'd0;
            mb     <= 32'd0;
            a_q    <= 32'd0;
            neg_q  <= 1'b0;
            rneg_q <= 1'b0;
            bz_q   <= 1'b0;
            acc    <= 64'd0;
            count  <= 5'd0;
            hi_q   <= 32'd0;
            lo_q   <= 32'd0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        op_q   <= bus.op;
                        ma     <= ma_in;
                        mb     <= mb_in;
                        a_q    <= bus.a;
                        neg_q  <= sgn_in & (bus.a[31] ^ bus.b[31]);
                        rneg_q <= sgn_in & bus.a[31];
                        bz_q   <= (bus.b == 32'd0);
                        acc    <= 64'd0;
                        count  <= 5'd0;
                    end else begin
                        if (bus.mthi) hi_q <= bus.wdata;
                        if (bus.mtlo) lo_q <= bus.wdata;
                    end
                end
                CALC: begin
                    count <= count + 5'd1;
                    if (op_q[1]) begin
                        acc <= {rnew, acc[30:0], qbit};
                        ma  <= {ma[30:0], 1'b0};
                    end else begin
                        acc <= {mul_sum, acc[31:1]};
                        mb  <= {1'b0, mb[31:1]};
                    end
                end
                FIX: begin
                    done_q <= 1'b1;
                    if (op_q[1]) begin
                        if (bz_q) begin
                            hi_q <= a_q;
                            lo_q <= 32'hFFFF_FFFF;
                        end else begin
                            hi_q <= r_fix;
                            lo_q <= q_fix;
                        end
                    end else begin
                        hi_q <= prod_fix[63:32];
                        lo_q <= prod_fix[31:0];
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.hi    = hi_q;
    assign bus.lo    = lo_q;
    assign bus.busy  = (state != IDLE);
    assign bus.done  = done_q;
    assign bus.stall = (state != IDLE) &
                       (bus.start | bus.mthi | bus.mtlo | bus.mfhi | bus.mflo);

endmodule

// File: doc/mdu_hilo.md
# mdu_hilo

Iterative multiply/divide unit with HI/LO registers for the R2000 pipeline, sitting beside the execute stage and fed directly by the decode stage. It executes MULT, MULTU, DIV and DIVU over 33 cycles and holds the 64-bit result in HI/LO for MFHI/MFLO. It also accepts MTHI/MTLO writes. Its `stall` output is ORed into the decode stage's `hold_pc`/`hold_if` to interlock any access to HI/LO while an operation is in flight.

## Interface
Parameters:
- `ITER`, default 32: iteration count in CALC; fixed at 32 for R2000 operand width.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  issue request from decode; valid for one cycle.
- `op`  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `a`  in  32  rs operand (multiplicand / dividend).
- `b`  in  32  rt operand (multiplier / divisor).
- `mthi`  in  1  write `wdata` to HI.
- `mtlo`  in  1  write `wdata` to LO.
- `mfhi`  in  1  decode is reading HI this cycle.
- `mflo`  in  1  decode is reading LO this cycle.
- `wdata`  in  32  MTHI/MTLO data.
- `hi`  out  32  HI register (registered).
- `lo`  out  32  LO register (registered).
- `busy`  out  1  state ≠ IDLE (registered).
- `done`  out  1  one-cycle pulse, cycle after HI/LO update.
- `stall`  out  1  combinational: `busy & (start | mthi | mtlo | mfhi | mflo)`.

## Operation
- States are IDLE, CALC and FIX.
- IDLE:
  - `start`=1 latches `op`, the operand magnitudes and the result sign flags.
  - Clears the 64-bit accumulator, sets count=0, goes to CALC.
  - Without `start`, `mthi`/`mtlo` write HI/LO at the edge.
  - `start` together with `mthi`/`mtlo` in the same cycle: `start` wins and the MT write is dropped.
- CALC: one iteration per edge, count 0..31, goes to FIX after the edge with count=31.
  - Multiply: radix-2 shift-add on the magnitudes, producing an unsigned 64-bit product.
  - Divide: restoring division on the magnitudes, producing a 32-bit quotient and remainder.
- FIX: sign correction, one edge, then HI/LO are written and the state returns to IDLE.
  - MULT: negate the 64-bit product (two's complement) if `a[31]^b[31]`. {HI,LO} = product.
  - DIV: negate the quotient if `a[31]^b[31]`. The remainder takes the sign of `a`. LO = quotient, HI = remainder.
  - MULTU/DIVU: no correction.
- Magnitude rule: |0x80000000| = 0x80000000, treated as unsigned 32-bit.
- DIV 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0 (wrap, no trap).
- Divide by zero (`b`=0, any divide op): full latency. LO=0xFFFFFFFF, HI=`a` (original operand, uncorrected). No exception is raised.
- While busy:
  - `start`, `mthi`, `mtlo` are ignored; `stall` holds decode, so the request re-presents after completion.
  - `mfhi`/`mflo` assert `stall`; HI/LO keep their previous values until FIX.
- Reset state: IDLE, hi=0, lo=0, busy=0, done=0, count=0, accumulator=0.
- `rst` mid-operation aborts the operation with no HI/LO update.

## Timing
- `start` sampled at edge E0, `busy`=1 from E0+ through edge E33.
- CALC occupies edges E1..E32. The FIX edge E33 writes HI/LO, and `busy` falls after E33.
- `done`=1 for exactly the cycle after E33.
- Total occupancy: 33 cycles of `busy`. A new `start` is accepted at E34 at the earliest.
- `stall` is combinational from inputs and the registered `busy`, with no added latency. The first stalled cycle is E0+1 if decode presents an HI/LO access then.
- MTHI/MTLO in IDLE: HI/LO reflect `wdata` in the cycle after the edge.
- `hi`/`lo` never change except at a FIX edge, an IDLE MT edge, or reset.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF:
  - `done` in the cycle after E33, HI=0xFFFFFFFE, LO=0x00000001.
  - `busy` high for exactly 33 cycles.
- MULT −3 × 7 (0xFFFFFFFD, 7): HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- DIV edge cases:
  - DIV −7 / 2: LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- DIVU 100 / 0: full latency, LO=0xFFFFFFFF, HI=100.
- MFHI asserted at E5 of a MULT:
  - `stall`=1 through the cycle containing E33, 0 after; HI changes only at E33.
  - A `start` issued during busy is ignored.
- MTLO 0x12345678 while idle gives LO=0x12345678 next cycle.
- `rst` asserted at E10 of a DIVU: busy=0, hi=lo=0, `done` never pulses.
